// File: rtl/serial_vector_assembler_pkg.sv
// Shared definitions for the serial vector assembler and the downstream reversal stage.
package serial_vector_assembler_pkg;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    STALL
  } asm_state_e;

  function automatic int cnt_w(input int k);
    return $clog2(k);
  endfunction

endpackage

// File: rtl/vector_out_reg.sv
// K-bit output register with valid/ready hold: a load always wins over a handshake
// on the same edge, and the data is kept after it has been consumed.
module vector_out_reg
  import serial_vector_assembler_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [K-1:0] load_data,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [K-1:0] m_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_vector_assembler.sv
// Assembles a serial bit stream into K-bit words; the final bit of a word goes straight
// into the output register so back-to-back words need no bubble cycle.
module serial_vector_assembler
  import serial_vector_assembler_pkg::*;
#(
  parameter int K         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  input  logic                  s_bit,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [K-1:0]          m_data,
  input  logic                  m_ready,
  output logic [cnt_w(K)-1:0]   bit_cnt,
  output logic [7:0]            word_cnt
);

  localparam int CW = cnt_w(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam bit REVERSED = (MSB_FIRST == serial_vector_assembler_pkg::MSB_FIRST);

  logic [CW-1:0] bit_cnt_q;
  logic [K-1:0]  shift_q;
  logic [7:0]    word_cnt_q;
  logic [CW-1:0] pos;
  logic [K-1:0]  next_word;
  logic          accept;
  logic          final_bit;
  logic          load;
  asm_state_e    state;

  // State is a pure function of the counter and the output register; STALL is the only
  // state that refuses input, because the next bit would complete a word with nowhere to go.
  always_comb begin
    state = IDLE;
    if (m_valid) begin
      state = (bit_cnt_q == LAST && !m_ready) ? STALL : HOLD;
    end else if (bit_cnt_q != '0) begin
      state = FILL;
    end
  end

  always_comb begin
    s_ready   = !flush && (state != STALL);
    accept    = s_valid && s_ready;
    final_bit = (bit_cnt_q == LAST);
    load      = accept && final_bit;
    pos       = REVERSED ? (LAST - bit_cnt_q) : bit_cnt_q;
    next_word = shift_q;
    next_word[pos] = s_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
    end else if (flush) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (accept) begin
      if (final_bit) begin
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        word_cnt_q <= word_cnt_q + 8'd1;
      end else begin
        bit_cnt_q <= bit_cnt_q + CW'(1);
        shift_q   <= next_word;
      end
    end
  end

  vector_out_reg #(
    .K(K)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(next_word),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data)
  );

  assign bit_cnt  = bit_cnt_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: doc/serial_vector_assembler.md
Name: serial_vector_assembler

Overview:
- Upstream stage of the vector-reversal block: assembles a serial bit stream into K-bit parallel words and presents each word on a valid/ready output.
- m_data drives the reversal stage's A input directly.
- Sustains full throughput: one word every K accepted bits, with no bubble cycles.
- One clock domain; synchronous, active-high reset.

Parameters:
- K, 4, word width in bits; legal K >= 2.
- MSB_FIRST, 0, bit order. 0: the first accepted bit lands in m_data[0]. 1: the first accepted bit lands in m_data[K-1].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of the partially assembled word.
- s_valid  input  1  serial bit valid.
- s_bit  input  1  serial data bit.
- s_ready  output  1  assembler can accept s_bit this cycle.
- m_valid  output  1  m_data holds a complete word.
- m_data  output  K  assembled word.
- m_ready  input  1  downstream accepts m_data this cycle.
- bit_cnt  output  $clog2(K)  number of bits held in the partial word.
- word_cnt  output  8  count of completed words handed to the output register; wraps 255 -> 0.

Behaviour:
- Reset, when reset=1 at an edge:
  - bit_cnt=0, shift register=0, m_valid=0, m_data=0, word_cnt=0.
  - reset overrides all other inputs.
- s_ready is combinational: s_ready = !flush && !(bit_cnt==K-1 && m_valid && !m_ready).
- A bit is accepted when s_valid && s_ready; s_bit is ignored otherwise.
- Accepting a non-final bit (bit_cnt < K-1):
  - the bit goes to position bit_cnt, or K-1-bit_cnt when MSB_FIRST=1;
  - bit_cnt increments.
- Accepting the final bit (bit_cnt == K-1):
  - the full word, including this bit, loads into m_data on the same edge;
  - m_valid=1, bit_cnt=0, shift register cleared, word_cnt increments.
- Latency: m_valid rises on the edge that accepts the K-th bit, so it is visible in the following cycle.
- Output handshake:
  - m_valid && m_ready at an edge clears m_valid, unless a new word loads at that same edge; then m_valid stays 1 and m_data takes the new word.
  - m_data holds stable while m_valid && !m_ready.
  - m_data is not cleared on handshake; it retains the last word.
- Backpressure: while the output word is unconsumed, up to K-1 further bits are accepted. s_ready drops only when the next bit would complete a word with nowhere to go.
- flush=1 at an edge:
  - bit_cnt=0, shift register cleared;
  - any s_bit presented that cycle is dropped (s_ready=0);
  - m_valid, m_data and word_cnt are unaffected, so an output handshake in the same cycle still completes.
- FSM, derived from bit_cnt and m_valid:
  - IDLE (bit_cnt=0, !m_valid)
  - FILL (bit_cnt>0, !m_valid)
  - HOLD (m_valid, bit_cnt<K-1)
  - STALL (m_valid, bit_cnt==K-1, !m_ready; s_ready low)
  - Transitions follow the rules above; no separate state register is required.
- word_cnt wraps from 255 to 0 without a flag.
- Reset mid-word, or with m_valid=1, discards everything. The word in m_data is lost and no handshake occurs.

Decomposition:
- Shared package: bit-order encodings LSB_FIRST=0 / MSB_FIRST=1, and a function cnt_w(K) = $clog2(K) used by this block and by the reversal bench.
- One sub-module, vector_out_reg: the K-bit output register with valid/ready hold logic.
- Shift register and bit counter stay in the top.

Test Plan (K=4):
- LSB-first capture: MSB_FIRST=0, m_ready=1, bits 1,0,1,1 on consecutive cycles -> m_valid=1 for one cycle with m_data=4'b1101; word_cnt=1.
- MSB-first capture: MSB_FIRST=1, same bits 1,0,1,1 -> m_data=4'b1011, i.e. the reversal stage would output 4'b1101.
- Backpressure:
  - setup: m_ready=0, stream 8 bits 1111_0000;
  - first word 4'b1111 holds; 3 more bits accepted; s_ready=0 at bit_cnt=3;
  - raise m_ready -> 4'b1111 consumed and 4'b0000 loads on the same edge; m_valid stays 1.
- Flush: after 2 bits (1,1), assert flush together with s_valid=1 -> bit_cnt=0, that bit dropped; then bits 0,1,0,1 -> m_data=4'b1010.
- Reset mid-operation: m_valid=1 holding 4'b0110 with bit_cnt=2, assert reset for one cycle -> m_valid=0, m_data=0, bit_cnt=0, word_cnt=0.
- Wrap and throughput: 256 back-to-back words with m_ready=1 -> every 4th cycle m_valid=1, no bubbles; word_cnt reads 0 after the 256th word.
